// File: rtl/sound_sequencer.sv
// sound_sequencer: streams a programmed run of ROM samples to the codec,
// with volume shift, optional looping, and busy/done status.
module sound_sequencer #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 12109
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   length,
  input  logic              loop,
  input  logic [2:0]        volume,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_clken,
  input  logic [DATA_W-1:0] rom_readdata,
  output logic [DATA_W-1:0] aud_data,
  output logic              aud_valid,
  input  logic              aud_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [ADDR_W:0]     r_len;
  logic                r_loop;
  logic [2:0]          r_vol;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_clken;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_done;
  logic                w_valid_nxt;
  logic                w_done_nxt;
  logic                w_latch;
  logic                w_capture;
  logic                w_last;
  logic [ADDR_W:0]     w_len_clamp;
  logic signed [DATA_W-1:0] w_scaled;

  assign w_len_clamp = (length > LP_DEPTH) ? LP_DEPTH : length;
  assign w_last      = ({1'b0, r_ptr} == (r_len - 1'b1));
  assign w_scaled    = $signed(rom_readdata) >>> r_vol;

  // stop outranks start; a start anywhere restarts from word 0
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    if (stop) begin
      if (r_state != S_IDLE) begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    end else if (start) begin
      w_valid_nxt = 1'b0;
      if (length == '0) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_latch     = 1'b1;
        w_ptr_nxt   = '0;
        w_state_nxt = S_FETCH;
      end
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_FETCH: w_state_nxt = S_WAIT;
        S_WAIT: begin
          w_capture   = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_PRESENT;
        end
        S_PRESENT: begin
          if (r_valid && aud_ready) begin
            w_valid_nxt = 1'b0;
            if (!w_last) begin
              w_ptr_nxt   = r_ptr + 1'b1;
              w_state_nxt = S_FETCH;
            end else if (r_loop) begin
              w_ptr_nxt   = '0;
              w_state_nxt = S_FETCH;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_len   <= '0;
      r_loop  <= 1'b0;
      r_vol   <= '0;
      r_addr  <= '0;
      r_clken <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_latch) begin
        r_len  <= w_len_clamp;
        r_loop <= loop;
        r_vol  <= volume;
      end
      if (w_state_nxt == S_FETCH) r_addr <= w_ptr_nxt;
      r_clken <= (w_state_nxt == S_FETCH);
      if (w_capture) r_data <= w_scaled;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign rom_address = r_addr;
  assign rom_clken   = r_clken;
  assign aud_data    = r_data;
  assign aud_valid   = r_valid;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: directed + randomized playback runs against a
// ROM model and a per-sample reference computed from the playback rules.
module tb_sound_sequencer;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 12109;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              stop;
  logic [ADDR_W:0]   length;
  logic              loop;
  logic [2:0]        volume;
  logic [ADDR_W-1:0] rom_address;
  logic              rom_clken;
  logic [DATA_W-1:0] rom_readdata;
  logic [DATA_W-1:0] aud_data;
  logic              aud_valid;
  logic              aud_ready;
  logic              busy;
  logic              done;

  sound_sequencer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .length      (length),
    .loop        (loop),
    .volume      (volume),
    .rom_address (rom_address),
    .rom_clken   (rom_clken),
    .rom_readdata(rom_readdata),
    .aud_data    (aud_data),
    .aud_valid   (aud_valid),
    .aud_ready   (aud_ready),
    .busy        (busy),
    .done        (done)
  );

  always #10 clk = ~clk;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rom_q;
  always @(posedge clk) if (rom_clken) rom_q <= mem[rom_address];
  assign rom_readdata = rom_q;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int ndone = 0;
  int dcyc = 0;
  logic [DATA_W-1:0] got[$];
  int xcyc[$];
  logic [ADDR_W-1:0] fa[$];
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_smp(input int idx,
                                               input int len,
                                               input int vol);
    int n;
    logic signed [DATA_W-1:0] s;
    n = (len > DEPTH) ? DEPTH : len;
    s = mem[idx % n];
    return s >>> vol;
  endfunction

  task automatic clr();
    got.delete();
    xcyc.delete();
    fa.delete();
    ndone = 0;
    dcyc = 0;
    prev_stall = 1'b0;
  endtask

  task automatic step();
    if (rdy_mode == 0) aud_ready = 1'b1;
    else if (rdy_mode == 1) aud_ready = ($urandom_range(0, 2) == 0);
    else aud_ready = 1'b0;
    #1;
    if (prev_stall && aud_valid) chk("stall_hold", aud_data, prev_data);
    prev_stall = aud_valid && !aud_ready;
    prev_data = aud_data;
    if (aud_valid && aud_ready) begin
      got.push_back(aud_data);
      xcyc.push_back(cyc);
    end
    if (rom_clken) fa.push_back(rom_address);
    if (done) begin
      ndone++;
      dcyc = cyc;
      chk("done_busy", busy, 0);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic go(input int len, input bit lp, input int vol);
    length = (ADDR_W+1)'(len);
    loop = lp;
    volume = 3'(vol);
    start = 1'b1;
    step();
  endtask

  task automatic run(input int budget, input int max_x);
    for (int i = 0; i < budget; i++) begin
      if (ndone > 0) break;
      if (max_x > 0 && got.size() >= max_x) break;
      step();
    end
  endtask

  initial begin
    int c0;
    int len;
    int vol;
    logic [DATA_W-1:0] e2 [4];
    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    length = '0;
    loop = 1'b0;
    volume = '0;
    aud_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    mem[0] = 16'h1000;
    mem[1] = 16'h8000;
    mem[2] = 16'h7FFF;
    mem[3] = 16'h0001;
    e2[0] = 16'h0400;
    e2[1] = 16'hE000;
    e2[2] = 16'h1FFF;
    e2[3] = 16'h0000;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_addr", rom_address, 0);
    chk("rst_clken", rom_clken, 0);
    chk("rst_data", aud_data, 0);
    chk("rst_valid", aud_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // basic 4-sample run, ready high
    clr();
    rdy_mode = 0;
    c0 = cyc;
    go(4, 0, 0);
    chk("f1_clken", rom_clken, 1);
    chk("f1_addr", rom_address, 0);
    chk("f1_busy", busy, 1);
    run(60, 0);
    chk("t1_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("t1_data", got[i], ref_smp(i, 4, 0));
      chk("t1_cyc", xcyc[i], c0 + 3 + 3 * i);
    end
    chk("t1_ndone", ndone, 1);
    chk("t1_dcyc", dcyc, c0 + 13);
    chk("t1_busy", busy, 0);

    // volume 2, sparse ready
    clr();
    rdy_mode = 1;
    go(4, 0, 2);
    run(200, 0);
    chk("t2_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("t2_data", got[i], e2[i]);
    chk("t2_ndone", ndone, 1);

    // looping, then stop while a sample is pending
    clr();
    rdy_mode = 0;
    go(3, 1, 0);
    run(100, 10);
    chk("t3_count", got.size(), 10);
    for (int i = 0; i < 10 && i < fa.size(); i++)
      chk("t3_addr", fa[i], i % 3);
    rdy_mode = 2;
    for (int i = 0; i < 10 && !aud_valid; i++) step();
    chk("t3_pend", aud_valid, 1);
    stop = 1'b1;
    step();
    chk("t3_valid", aud_valid, 0);
    chk("t3_busy", busy, 0);
    repeat (4) step();
    chk("t3_ndone", ndone, 0);
    chk("t3_count2", got.size(), 10);

    // length 0
    clr();
    go(0, 0, 0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    step();
    chk("z_done2", done, 0);
    chk("z_fetch", fa.size(), 0);

    // length clamp to DEPTH
    clr();
    rdy_mode = 0;
    vol = $urandom_range(0, 7);
    go(20000, 0, vol);
    run(DEPTH * 3 + 40, 0);
    chk("cl_count", got.size(), DEPTH);
    chk("cl_last", (fa.size() > 0) ? fa[fa.size()-1] : 0, DEPTH - 1);
    for (int i = 0; i < got.size() && i < DEPTH; i++)
      chk("cl_data", got[i], ref_smp(i, 20000, vol));
    chk("cl_ndone", ndone, 1);

    // start + stop together while playing
    clr();
    go(5, 1, 0);
    repeat (4) step();
    start = 1'b1;
    stop = 1'b1;
    step();
    chk("ss_busy", busy, 0);
    chk("ss_valid", aud_valid, 0);
    repeat (5) step();
    chk("ss_ndone", ndone, 0);
    chk("ss_fetch", rom_clken, 0);

    // restart during PRESENT drops the pending sample
    clr();
    rdy_mode = 0;
    go(5, 0, 0);
    run(30, 1);
    rdy_mode = 2;
    for (int i = 0; i < 10 && !aud_valid; i++) step();
    chk("rs_pend", aud_valid, 1);
    go(2, 0, 0);
    chk("rs_addr", rom_address, 0);
    chk("rs_clken", rom_clken, 1);
    chk("rs_valid", aud_valid, 0);
    rdy_mode = 0;
    run(30, 0);
    chk("rs_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk("rs_data", got[i], ref_smp((i == 0) ? 0 : i - 1, 5, 0));
    chk("rs_ndone", ndone, 1);

    // randomized short runs
    for (int k = 0; k < 6; k++) begin
      clr();
      rdy_mode = 1;
      len = $urandom_range(1, 8);
      vol = $urandom_range(0, 7);
      go(len, 0, vol);
      run(300, 0);
      chk("rn_count", got.size(), len);
      for (int i = 0; i < got.size() && i < len; i++)
        chk("rn_data", got[i], ref_smp(i, len, vol));
      chk("rn_ndone", ndone, 1);
      chk("rn_busy", busy, 0);
    end

    // asynchronous reset while a sample is presented
    clr();
    rdy_mode = 2;
    go(4, 0, 0);
    for (int i = 0; i < 10 && !aud_valid; i++) step();
    chk("ar_pend", aud_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_valid", aud_valid, 0);
    chk("ar_data", aud_data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", rom_address, 0);
    chk("ar_clken", rom_clken, 0);
    chk("ar_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    prev_stall = 1'b0;
    repeat (2) step();
    chk("ar_idle", busy, 0);
    chk("ar_valid2", aud_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
